// File: rtl/glitch_cmd_pkg.sv
// Shared definitions for the glitcher UART command protocol.
// Holds the command byte values, field-enable bit positions, the sender
// state encoding and helpers that map field enables and snapshot values
// onto the fixed 15-slot frame table.
package glitch_cmd_pkg;

  localparam int unsigned NUM_SLOTS = 15;

  localparam logic [7:0] CMD_DELAY      = 8'h64;  // 'd'
  localparam logic [7:0] CMD_WIDTH      = 8'h77;  // 'w'
  localparam logic [7:0] CMD_NUM_PULSES = 8'h6E;  // 'n'
  localparam logic [7:0] CMD_SPACING    = 8'h73;  // 's'
  localparam logic [7:0] CMD_RESET_LEN  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_ARM        = 8'h61;  // 'a'
  localparam logic [7:0] CMD_TRIGGER    = 8'h74;  // 't'
  localparam logic [7:0] CMD_HELLO      = 8'h68;  // 'h'

  localparam int unsigned FLD_DELAY      = 0;
  localparam int unsigned FLD_WIDTH      = 1;
  localparam int unsigned FLD_NUM_PULSES = 2;
  localparam int unsigned FLD_SPACING    = 3;
  localparam int unsigned FLD_RESET_LEN  = 4;
  localparam int unsigned FLD_ARM        = 5;
  localparam int unsigned FLD_TRIGGER    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Expand the 7 field enables into one enable bit per frame slot.
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [6:0] en);
    slot_mask = {en[FLD_TRIGGER], en[FLD_ARM],
                 {3{en[FLD_RESET_LEN]}}, {3{en[FLD_SPACING]}},
                 {2{en[FLD_NUM_PULSES]}}, {2{en[FLD_WIDTH]}},
                 {3{en[FLD_DELAY]}}};
  endfunction

  // Byte carried by a given frame slot; multi-byte fields go MSB first.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  slot,
    input logic [15:0] delay,
    input logic [7:0]  width,
    input logic [7:0]  num_pulses,
    input logic [15:0] spacing,
    input logic [15:0] reset_len
  );
    case (slot)
      4'd0:    frame_byte = CMD_DELAY;
      4'd1:    frame_byte = delay[15:8];
      4'd2:    frame_byte = delay[7:0];
      4'd3:    frame_byte = CMD_WIDTH;
      4'd4:    frame_byte = width;
      4'd5:    frame_byte = CMD_NUM_PULSES;
      4'd6:    frame_byte = num_pulses;
      4'd7:    frame_byte = CMD_SPACING;
      4'd8:    frame_byte = spacing[15:8];
      4'd9:    frame_byte = spacing[7:0];
      4'd10:   frame_byte = CMD_RESET_LEN;
      4'd11:   frame_byte = reset_len[15:8];
      4'd12:   frame_byte = reset_len[7:0];
      4'd13:   frame_byte = CMD_ARM;
      4'd14:   frame_byte = CMD_TRIGGER;
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_slot_sel.sv
// Next-enabled-slot priority search.
// Ports: from_slot  - first slot index eligible (inclusive, may be 15 = none)
//        slot_mask  - per-slot enable bits
//        next_slot  - lowest enabled slot index >= from_slot
//        none_left  - no enabled slot at or after from_slot
module uart_cmd_slot_sel
  import glitch_cmd_pkg::*;
(
  input  logic [4:0]           from_slot,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [3:0]           next_slot,
  output logic                 none_left
);

  // Scan from the top down so the lowest eligible index is written last.
  always_comb begin
    next_slot = 4'd0;
    none_left = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      next_slot = (slot_mask[i] && (5'(i) >= from_slot)) ? 4'(i) : next_slot;
      none_left = (slot_mask[i] && (5'(i) >= from_slot)) ? 1'b0 : none_left;
    end
  end

endmodule

// File: rtl/uart_cmd_sender.sv
// UART command-stream initiator: snapshots glitch parameters on send_i and
// streams the enabled command frames as bytes over a valid/ready handshake.
// Ports: clk, rst_n (async active-low)
//        send_i, field_en_i, delay_i, width_i, num_pulses_i,
//        pulse_spacing_i, reset_length_i  - request and parameters
//        byte_data_o, byte_valid_o, byte_ready_i - byte stream to uart_tx
//        busy_o, done_o                     - sequence status
module uart_cmd_sender
  import glitch_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_i,
  input  logic [6:0]  field_en_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  output logic [7:0]  byte_data_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  logic [1:0]  rst_sync_r;
  logic        rst_int_n_s;

  state_t      state_r;
  logic [3:0]  slot_r;
  logic [6:0]  en_r;
  logic [15:0] delay_r;
  logic [7:0]  width_r;
  logic [7:0]  num_pulses_r;
  logic [15:0] spacing_r;
  logic [15:0] reset_len_r;

  logic [4:0]           search_from_s;
  logic [NUM_SLOTS-1:0] search_mask_s;
  logic [3:0]           next_slot_s;
  logic                 none_left_s;
  logic [7:0]           next_byte_s;

  // Reset synchronizer: assert immediately, release on the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // In IDLE the search and byte lookup use the live inputs (they are being
  // snapshotted this very cycle); afterwards only the snapshot is used.
  always_comb begin
    if (state_r == ST_IDLE) begin
      search_from_s = 5'd0;
      search_mask_s = slot_mask(field_en_i);
    end else begin
      search_from_s = {1'b0, slot_r} + 5'd1;
      search_mask_s = slot_mask(en_r);
    end
  end

  uart_cmd_slot_sel u_slot_sel (
    .from_slot (search_from_s),
    .slot_mask (search_mask_s),
    .next_slot (next_slot_s),
    .none_left (none_left_s)
  );

  // Byte for the slot the search selected, from live inputs or snapshot.
  always_comb begin
    if (state_r == ST_IDLE) begin
      next_byte_s = frame_byte(next_slot_s, delay_i, width_i, num_pulses_i,
                               pulse_spacing_i, reset_length_i);
    end else begin
      next_byte_s = frame_byte(next_slot_s, delay_r, width_r, num_pulses_r,
                               spacing_r, reset_len_r);
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r      <= ST_IDLE;
      slot_r       <= 4'd0;
      en_r         <= 7'd0;
      delay_r      <= 16'd0;
      width_r      <= 8'd0;
      num_pulses_r <= 8'd0;
      spacing_r    <= 16'd0;
      reset_len_r  <= 16'd0;
      byte_data_o  <= 8'd0;
      byte_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (send_i) begin
            en_r         <= field_en_i;
            delay_r      <= delay_i;
            width_r      <= width_i;
            num_pulses_r <= num_pulses_i;
            spacing_r    <= pulse_spacing_i;
            reset_len_r  <= reset_length_i;
            if (!none_left_s) begin
              state_r      <= ST_SEND;
              slot_r       <= next_slot_s;
              byte_data_o  <= next_byte_s;
              byte_valid_o <= 1'b1;
              busy_o       <= 1'b1;
            end else begin
              state_r <= ST_FINISH;
              done_o  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          // Valid is always high here, so ready alone marks a transfer.
          if (byte_ready_i) begin
            if (!none_left_s) begin
              slot_r      <= next_slot_s;
              byte_data_o <= next_byte_s;
            end else begin
              state_r      <= ST_FINISH;
              slot_r       <= 4'd0;
              byte_data_o  <= 8'd0;
              byte_valid_o <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          slot_r       <= 4'd0;
          byte_data_o  <= 8'd0;
          byte_valid_o <= 1'b0;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
